// File: rtl/seg7_receptor_pkg.sv
// rtl/seg7_receptor_pkg.sv - shared glyph table, segment positions and FSM encoding
package seg7_receptor_pkg;

  // Bit positions inside a {a,b,c,d,e,f,g} segment word
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  typedef logic [6:0] seg_t;

  typedef enum logic [1:0] {
    ESPERA     = 2'd0,
    ESTABILIZA = 2'd1,
    FIJO       = 2'd2
  } estado_t;

  // Lit-segment masks (1 = segment on) for hex digits 0..F
  localparam seg_t GLYPH_LIT [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  function automatic seg_t hex_a_seg(input logic [3:0] valor);
    return GLYPH_LIT[valor];
  endfunction

endpackage

// File: rtl/seg7_receptor_if.sv
// rtl/seg7_receptor_if.sv - segment input and decoded-digit output bundle
interface seg7_receptor_if;
  import seg7_receptor_pkg::*;

  seg_t       seg;
  logic       en;
  logic [3:0] valor;
  logic       valido;
  logic       cambio;
  logic       error;
  logic [7:0] cuenta_err;

  modport master (
    output seg, en,
    input  valor, valido, cambio, error, cuenta_err
  );

  modport slave (
    input  seg, en,
    output valor, valido, cambio, error, cuenta_err
  );

endinterface

// File: rtl/seg7_a_hex.sv
// rtl/seg7_a_hex.sv - combinational lit-segment to hex lookup with legal flag
module seg7_a_hex
  import seg7_receptor_pkg::*;
(
  input  seg_t       lit,
  output logic [3:0] valor,
  output logic       legal
);

  always_comb begin
    valor = 4'h0;
    legal = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (lit == GLYPH_LIT[i]) begin
        valor = 4'(i);
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_receptor.sv
// rtl/seg7_receptor.sv - debounced seven-segment pattern receiver with glyph decode
module seg7_receptor
  import seg7_receptor_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  seg7_receptor_if.slave   bus
);

  localparam seg_t       SEG_OFF    = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

  seg_t       seg_q;
  seg_t       held;
  seg_t       held_lit;
  estado_t    estado;
  logic [7:0] cnt;
  logic [3:0] valor_q;
  logic       valido_q;
  logic       cambio_q;
  logic       error_q;
  logic [7:0] cuenta_q;
  logic [3:0] dec_valor;
  logic       dec_legal;

  assign held_lit = ACTIVE_LOW ? ~held : held;

  seg7_a_hex u_a_hex (
    .lit   (held_lit),
    .valor (dec_valor),
    .legal (dec_legal)
  );

  // seg_q resets to the blank pattern, so the first ESPERA load holds "off"
  // and a real glyph then reloads the counter to 1 like any other change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q    <= SEG_OFF;
      held     <= SEG_OFF;
      estado   <= ESPERA;
      cnt      <= 8'd0;
      valor_q  <= 4'h0;
      valido_q <= 1'b0;
      cambio_q <= 1'b0;
      error_q  <= 1'b0;
      cuenta_q <= 8'd0;
    end else begin
      seg_q    <= bus.seg;
      cambio_q <= 1'b0;
      if (bus.en) begin
        unique case (estado)
          ESPERA: begin
            held   <= seg_q;
            cnt    <= 8'd0;
            estado <= ESTABILIZA;
          end
          ESTABILIZA: begin
            if (seg_q != held) begin
              held <= seg_q;
              cnt  <= 8'd1;
            end else if (cnt >= STABLE_CNT - 8'd1) begin
              cnt    <= STABLE_CNT;
              estado <= FIJO;
              if (dec_legal) begin
                valor_q  <= dec_valor;
                valido_q <= 1'b1;
                error_q  <= 1'b0;
                cambio_q <= (dec_valor != valor_q) || !valido_q;
              end else begin
                valido_q <= 1'b0;
                error_q  <= 1'b1;
                if (cuenta_q != 8'hFF) begin
                  cuenta_q <= cuenta_q + 8'd1;
                end
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          FIJO: begin
            if (seg_q != held) begin
              held     <= seg_q;
              cnt      <= 8'd1;
              estado   <= ESTABILIZA;
              valido_q <= 1'b0;
              error_q  <= 1'b0;
            end
          end
          default: begin
            estado <= ESPERA;
          end
        endcase
      end
    end
  end

  assign bus.valor      = valor_q;
  assign bus.valido     = valido_q;
  assign bus.cambio     = cambio_q;
  assign bus.error      = error_q;
  assign bus.cuenta_err = cuenta_q;

endmodule

// File: tb/tb_seg7_receptor.sv
// tb/tb_seg7_receptor.sv - randomized and directed bench with a run-length reference model
module tb_seg7_receptor;

  localparam int ST = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] lit = 7'h00;
  logic       en  = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_receptor_if bus_lo ();
  seg7_receptor_if bus_hi ();

  assign bus_lo.seg = ~lit;
  assign bus_hi.seg = lit;
  assign bus_lo.en  = en;
  assign bus_hi.en  = en;

  seg7_receptor #(.STABLE_CYCLES(ST), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk (clk),
    .rst (rst),
    .bus (bus_lo.slave)
  );

  seg7_receptor #(.STABLE_CYCLES(ST), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk (clk),
    .rst (rst),
    .bus (bus_hi.slave)
  );

  // Glyph table built from segment letters, independent of the design package
  string      glyph_str [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                                 "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                                 "cdefg", "adef", "bcdeg", "adefg", "aefg"};
  logic [6:0] glyph [16];

  function automatic logic [6:0] lit_of(input string s);
    logic [6:0] m = 7'h00;
    for (int k = 0; k < s.len(); k++) m[6 - (int'(s[k]) - 97)] = 1'b1;
    return m;
  endfunction

  // Reference: count how many consecutive enabled samples match the current pattern
  logic [6:0] m_sq, m_pat;
  int         m_run, m_valor, m_cnt;
  bit         m_started, m_valido, m_cambio, m_error;

  task automatic model_reset();
    m_sq = 7'h00; m_pat = 7'h00; m_run = 0; m_started = 1'b0;
    m_valor = 0; m_valido = 1'b0; m_cambio = 1'b0; m_error = 1'b0; m_cnt = 0;
  endtask

  task automatic model_accept();
    int v = -1;
    for (int i = 0; i < 16; i++) if (glyph[i] == m_pat) v = i;
    if (v >= 0) begin
      m_cambio = (v != m_valor) || !m_valido;
      m_valor  = v;
      m_valido = 1'b1;
      m_error  = 1'b0;
    end else begin
      m_valido = 1'b0;
      m_error  = 1'b1;
      m_cnt    = (m_cnt < 255) ? m_cnt + 1 : 255;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        m_cambio = 1'b0;
        if (en) begin
          if (!m_started) begin
            m_started = 1'b1; m_pat = m_sq; m_run = 0;
          end else if (m_sq != m_pat) begin
            m_pat = m_sq; m_run = 1; m_valido = 1'b0; m_error = 1'b0;
          end else if (m_run < ST) begin
            m_run++;
            if (m_run == ST) model_accept();
          end
        end
        m_sq = lit;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string tag, input logic [3:0] v, input logic vd,
                         input logic c, input logic e, input logic [7:0] ce);
    check({tag, "_valor"},      32'(v),  32'(m_valor));
    check({tag, "_valido"},     32'(vd), 32'(m_valido));
    check({tag, "_cambio"},     32'(c),  32'(m_cambio));
    check({tag, "_error"},      32'(e),  32'(m_error));
    check({tag, "_cuenta_err"}, 32'(ce), 32'(m_cnt));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp_dut("lo", bus_lo.valor, bus_lo.valido, bus_lo.cambio, bus_lo.error, bus_lo.cuenta_err);
      cmp_dut("hi", bus_hi.valor, bus_hi.valido, bus_hi.cambio, bus_hi.error, bus_hi.cuenta_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int first, pulses;

  initial begin
    for (int i = 0; i < 16; i++) glyph[i] = lit_of(glyph_str[i]);
    repeat (3) tick();
    check("rst_valor", 32'(bus_lo.valor), 0);
    check("rst_valido", 32'(bus_lo.valido), 0);
    check("rst_cuenta", 32'(bus_lo.cuenta_err), 0);

    // Lamp test: "0" from reset release, pulse on the fifth edge
    lit = glyph[0]; en = 1'b1;
    tick();
    rst = 1'b0;
    first = 0; pulses = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (bus_lo.cambio) begin pulses++; if (first == 0) first = k; end
    end
    check("lamp_cycle", 32'(first), 5);
    check("lamp_pulses", 32'(pulses), 1);
    check("lamp_valor", 32'(bus_lo.valor), 0);
    check("lamp_valido", 32'(bus_lo.valido), 1);

    // Glitch restarts the count
    pulses = 0;
    lit = glyph[1];
    repeat (3) begin tick(); if (bus_lo.cambio) pulses++; end
    lit = 7'h00;
    tick(); if (bus_lo.cambio) pulses++;
    check("glitch_no_early", 32'(pulses), 0);
    lit = glyph[1];
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (bus_lo.cambio && first == 0) first = k;
    end
    check("glitch_latency", 32'(first), 5);
    check("glitch_valor", 32'(bus_lo.valor), 1);

    // Illegal pattern (g only)
    lit = 7'h01;
    repeat (5) tick();
    check("illegal_error", 32'(bus_lo.error), 1);
    check("illegal_valido", 32'(bus_lo.valido), 0);
    check("illegal_cuenta", 32'(bus_lo.cuenta_err), 1);
    check("illegal_valor", 32'(bus_lo.valor), 1);

    // Saturation of the illegal counter
    for (int i = 0; i < 300; i++) begin
      lit = (i % 2 == 1) ? 7'h01 : 7'h00;
      repeat (ST) tick();
    end
    tick();
    check("sat_lo", 32'(bus_lo.cuenta_err), 255);
    check("sat_hi", 32'(bus_hi.cuenta_err), 255);

    // Enable freeze with a partial count in flight
    lit = glyph[2];
    repeat (2) tick();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      lit = 7'($urandom);
      tick();
      check("frz_valor", 32'(bus_lo.valor), 1);
      check("frz_valido", 32'(bus_lo.valido), 0);
      check("frz_cambio", 32'(bus_lo.cambio), 0);
      check("frz_cuenta", 32'(bus_lo.cuenta_err), 255);
    end
    lit = glyph[2];
    tick();
    en = 1'b1;
    first = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (bus_lo.cambio && first == 0) first = k;
    end
    check("frz_resume", 32'(first), 3);
    check("frz_valor2", 32'(bus_lo.valor), 2);

    // Re-acceptance and long hold
    pulses = 0;
    for (int j = 0; j < 3; j++) begin
      lit = glyph[(j == 1) ? 6 : 5];
      repeat (6) begin tick(); if (bus_lo.cambio) pulses++; end
    end
    check("reacc_pulses", 32'(pulses), 3);
    check("reacc_valor", 32'(bus_lo.valor), 5);
    pulses = 0;
    repeat (20) begin tick(); if (bus_lo.cambio) pulses++; end
    check("hold_pulses", 32'(pulses), 0);

    // Asynchronous reset mid-ESTABILIZA
    lit = glyph[3];
    repeat (2) tick();
    #1 rst = 1'b1;
    #1;
    check("arst_valor", 32'(bus_lo.valor), 0);
    check("arst_valido", 32'(bus_hi.valido), 0);
    check("arst_cuenta", 32'(bus_lo.cuenta_err), 0);
    check("arst_cambio", 32'(bus_hi.cambio), 0);
    tick();
    rst = 1'b0;
    pulses = 0;
    repeat (3) begin tick(); if (bus_lo.cambio || bus_hi.cambio) pulses++; end
    check("arst_no_cambio", 32'(pulses), 0);

    // Sweep of all glyphs in both polarities
    for (int i = 0; i < 16; i++) begin
      lit = glyph[i];
      repeat (6) tick();
      check("sweep_lo", 32'(bus_lo.valor), 32'(i));
      check("sweep_hi", 32'(bus_hi.valor), 32'(i));
      check("sweep_valido", 32'(bus_hi.valido), 1);
    end

    // Randomized traffic against the model
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 9) < 7) lit = glyph[$urandom_range(0, 15)];
      else lit = 7'($urandom);
      repeat ($urandom_range(1, 2 * ST + 2)) begin
        en = ($urandom_range(0, 9) != 0);
        tick();
      end
      if ($urandom_range(0, 49) == 0) begin
        #1 rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_receptor.md
SEG7_RECEPTOR -- requirements
Module: seg7_receptor

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive identical SEG samples (range 2..255) required to accept a pattern.
REQ-002 Parameter ACTIVE_LOW, default 1: 1 = segment lit when its bit is 0 (common anode); 0 = lit when its bit is 1.
REQ-003 CLK  input  1  single clock, rising-edge active.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 SEG  input  7  segment pattern {a,b,c,d,e,f,g}, SEG[6]=a, SEG[0]=g, sampled every CLK.
REQ-006 EN  input  1  capture enable; when 0, the stability filter holds its state.
REQ-007 VALOR  output  4  last accepted hex digit 0x0-0xF.
REQ-008 VALIDO  output  1  high while VALOR reflects the currently stable, legal pattern.
REQ-009 CAMBIO  output  1  one-cycle pulse when a new legal value is accepted.
REQ-010 ERROR  output  1  high while the stable pattern is not one of the 16 legal glyphs.
REQ-011 CUENTA_ERR  output  8  saturating count of accepted illegal patterns.

Function
REQ-012 Legal glyphs (lit segments): 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg, A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg.
REQ-013 SEG is registered once before use; all latencies below count from that register.
REQ-014 The FSM has 3 states: ESPERA, ESTABILIZA and FIJO; its reset state is ESPERA.
REQ-015 In ESPERA, when EN=1, the module loads the sample, clears the stability counter and goes to ESTABILIZA.
REQ-016 In ESTABILIZA, when EN=1 and the sample equals the held sample, the counter increments.
REQ-017 In ESTABILIZA, when EN=1 and the sample differs, the module reloads the sample, resets the counter to 1 and stays in ESTABILIZA.
REQ-018 When the counter reaches STABLE_CYCLES, the module decodes the held sample and goes to FIJO.
REQ-019 On a legal decode: VALOR is updated, VALIDO=1 and ERROR=0; CAMBIO pulses only if the value differs from the previous VALOR or VALIDO was 0.
REQ-020 On an illegal decode: VALOR is held, VALIDO=0, ERROR=1, CAMBIO=0, and CUENTA_ERR increments, saturating at 0xFF.
REQ-021 In FIJO, any sample differing from the held sample drops VALIDO and ERROR to 0 on the next cycle and returns the FSM to ESTABILIZA with the counter at 1.
REQ-022 A held pattern in FIJO causes no further CAMBIO pulses or CUENTA_ERR increments.
REQ-023 With EN=0, state, counter and outputs are frozen and SEG changes are ignored; CAMBIO is 0.
REQ-024 Acceptance latency is STABLE_CYCLES+1 CLK cycles from the first SEG edge of a stable pattern to VALIDO/CAMBIO.
REQ-025 The stability counter is wide enough for 255 and never wraps.
REQ-026 Mid-sequence glitches restart the count; there is no partial credit.
REQ-027 Decode honours ACTIVE_LOW by inverting SEG before table lookup when ACTIVE_LOW=1.

Reset
REQ-028 RST=1 forces, immediately and asynchronously: FSM=ESPERA, counter=0, held sample=all segments off, VALOR=0, VALIDO=0, CAMBIO=0, ERROR=0, CUENTA_ERR=0.
REQ-029 Reset asserted mid-ESTABILIZA discards the partial sample, and no CAMBIO pulse follows release.
REQ-030 The first capture after reset release starts in the first cycle with EN=1.

Structure
REQ-031 The shared package holds the 16-entry glyph table, the segment bit-position constants and the FSM state encoding, so the existing 4-to-7 decoder and this receiver use one source of truth.
REQ-032 One sub-module, seg7_a_hex, is natural: a combinational 7-to-4 lookup with a legal flag; the FSM, counters and registers live in seg7_receptor.

Verification
REQ-033 Lamp test (ACTIVE_LOW=1, EN=1): SEG=0x01 ("0") held 6 cycles -> VALOR=0, VALIDO=1 and one CAMBIO pulse on cycle 5.
REQ-034 Glitch: SEG=0x4F ("1") for 3 cycles, then 0x00 for 1 cycle, then 0x4F held -> no acceptance until 5 cycles after the return to 0x4F; VALOR=1.
REQ-035 Illegal pattern: SEG=0x7E held 5 cycles -> ERROR=1, VALIDO=0, CUENTA_ERR=1, VALOR unchanged; 300 alternating illegal/blank patterns -> CUENTA_ERR saturates at 0xFF.
REQ-036 Re-acceptance: the same legal value is re-accepted after an intervening different stable value -> CAMBIO pulses once per change; an unchanged long hold -> exactly one pulse.
REQ-037 EN freeze: EN=0 for 10 cycles while SEG toggles -> all outputs constant; EN=1 -> filtering resumes from the frozen count.
REQ-038 Async reset: assert RST between clock edges during ESTABILIZA -> outputs clear before the next edge; no CAMBIO after release.
REQ-039 Sweep: all 16 glyphs in both ACTIVE_LOW settings -> VALOR matches the REQ-012 table.
